wishbone_arbiter: RTL and testbench
===================================

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, the number of cycles a granted transfer may wait for ack before abort.
REQ-002 The block SHALL have parameter ADDR_W, default 32, the Wishbone address width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 The block SHALL have port m0  wishbone_if.slave  -  requester 0 (instruction fetch); fields cycle, strobe, address, data_in, write_enable, data_out, ack.
REQ-006 The block SHALL have port m1  wishbone_if.slave  -  requester 1 (data load/store); same fields.
REQ-007 The block SHALL have port s  wishbone_if.master  -  the shared slave (program ROM or RAM).
REQ-008 The block SHALL have port timeout_error  output  1  one-cycle pulse when a transfer is aborted by timeout.
REQ-009 The block SHALL have port grant  output  2  one-hot current owner (bit0=m0, bit1=m1); 2'b00 when no owner.

Function
REQ-010 The block SHALL implement the states IDLE, BUSY and RELEASE.
REQ-011 IDLE: a requester is pending when cycle&&strobe; on the next clock edge the arbiter SHALL latch the winner, set grant, and go to BUSY.
REQ-012 Arbitration SHALL be round-robin: with both pending, the requester not granted last wins; last_grant resets to m1, so m0 wins the first tie.
REQ-013 BUSY: s.cycle, s.strobe, s.address, s.data_in and s.write_enable SHALL be combinationally driven from the granted requester only.
REQ-014 BUSY: s.data_out SHALL be routed to both requesters' data_out, and s.ack SHALL go to the granted requester's ack only; the other ack SHALL be 0.
REQ-015 BUSY: when s.ack=1, the arbiter SHALL go to RELEASE on that edge, update last_grant, and clear grant.
REQ-016 BUSY: if the owner drops cycle before ack, the arbiter SHALL go to RELEASE without any ack.
REQ-017 BUSY: a wait counter SHALL count cycles in BUSY, width $clog2(TIMEOUT_CYCLES+1).
REQ-018 Timeout: when the wait counter reaches TIMEOUT_CYCLES with no ack, the arbiter SHALL go to RELEASE and pulse timeout_error for 1 cycle; the requester receives no ack.
REQ-019 RELEASE: s.cycle and s.strobe SHALL be 0 for exactly 1 cycle, then the arbiter returns to IDLE; this gives the slave time to leave its post-ack state.
REQ-020 IDLE and RELEASE: all s.* outputs SHALL be 0, and both requester acks SHALL be 0.
REQ-021 Minimum occupancy of the slave SHALL be grant cycle + slave latency + 1 RELEASE cycle; back-to-back requests from the same master SHALL see at least one idle cycle between acks.
REQ-022 A request arriving in RELEASE SHALL be considered in the following IDLE; no request is dropped while cycle&&strobe is held.
REQ-023 A requester's ack SHALL never be asserted while its own cycle is 0.

Reset
REQ-024 When reset=0, the block SHALL asynchronously force state=IDLE, grant=2'b00, last_grant=m1, wait counter=0 and timeout_error=0.
REQ-025 During reset, all s.* outputs and both requester acks SHALL be 0.
REQ-026 A reset asserted mid-transfer SHALL abort the transfer with no ack to any requester.

Structure
REQ-027 The state enum arb_state_t and the default TIMEOUT_CYCLES constant SHALL live in shared package bus_pkg.
REQ-028 Round-robin winner selection SHALL be one sub-module rr_select_2: inputs req[1:0] and last; output one-hot winner; purely combinational.
REQ-029 wishbone_if SHALL be reused unchanged.

Verification
REQ-030 m0 only: read 0x0000_0004 -> grant=01, s.address=0x4, m0.ack pulses once with ROM word[1], m1.ack stays 0.
REQ-031 m0 and m1 request in the same cycle, from reset -> m0 served first, m1 granted after one RELEASE cycle; a repeat tie -> m0 wins again, since last_grant=m1.
REQ-032 Both requesters hold requests continuously for 6 transfers -> grants alternate 01,10,01,10,01,10; no starvation.
REQ-033 Slave never acks, TIMEOUT_CYCLES=8 -> after 8 BUSY cycles timeout_error=1 for 1 cycle, no ack, and a subsequent request is granted normally.
REQ-034 reset driven to 0 in BUSY before ack -> state IDLE immediately (asynchronous), grant=00, no ack ever issued for that transfer.
REQ-035 Owner drops cycle mid-BUSY -> RELEASE, then IDLE, with no ack and no timeout_error.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding and default ack-timeout length.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/wishbone_if.sv
// Minimal Wishbone bundle shared by requesters and the slave.
interface wishbone_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cycle;
  logic              strobe;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              write_enable;
  logic [DATA_W-1:0] data_out;
  logic              ack;

  modport master (output cycle, strobe, address, data_in, write_enable,
                  input  data_out, ack);
  modport slave  (input  cycle, strobe, address, data_in, write_enable,
                  output data_out, ack);
endinterface

// File: rtl/rr_select_2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_select_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);
  // last = 1 means requester 1 was granted most recently.
  always_comb begin
    if (req == 2'b11) winner = last ? 2'b01 : 2'b10;
    else              winner = req;
  end
endmodule

// File: rtl/wishbone_arbiter.sv
// Two-requester Wishbone arbiter for a single shared slave, with ack timeout
// and a one-cycle release gap after every transfer.
module wishbone_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int ADDR_W         = 32
) (
  input  logic       clk,
  input  logic       reset,
  wishbone_if.slave  m0,
  wishbone_if.slave  m1,
  wishbone_if.master s,
  output logic       timeout_error,
  output logic [1:0] grant
);
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state, state_nxt;
  logic [1:0]        grant_nxt;
  logic              last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              timeout_nxt;
  logic [1:0]        req, winner;
  logic              owner_cyc, owner_ack;
  logic [ADDR_W-1:0] mux_addr;

  assign req = {m1.cycle & m1.strobe, m0.cycle & m0.strobe};

  rr_select_2 u_rr (
    .req    (req),
    .last   (last_grant),
    .winner (winner)
  );

  // Ack only counts while the owner still holds cycle, so a late slave ack
  // can never reach a requester that has already walked away.
  assign owner_cyc = (state == BUSY) &&
                     ((grant[0] && m0.cycle) || (grant[1] && m1.cycle));
  assign owner_ack = owner_cyc && s.ack;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mux_addr       = '0;
    s.cycle        = 1'b0;
    s.strobe       = 1'b0;
    s.data_in      = '0;
    s.write_enable = 1'b0;
    m0.ack         = 1'b0;
    m1.ack         = 1'b0;
    m0.data_out    = s.data_out;
    m1.data_out    = s.data_out;
    if (state == BUSY) begin
      if (grant[0]) begin
        s.cycle        = m0.cycle;
        s.strobe       = m0.strobe;
        mux_addr       = m0.address;
        s.data_in      = m0.data_in;
        s.write_enable = m0.write_enable;
        m0.ack         = owner_ack;
      end else if (grant[1]) begin
        s.cycle        = m1.cycle;
        s.strobe       = m1.strobe;
        mux_addr       = m1.address;
        s.data_in      = m1.data_in;
        s.write_enable = m1.write_enable;
        m1.ack         = owner_ack;
      end
    end
    s.address = mux_addr;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = wait_cnt;
    timeout_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = BUSY;
          grant_nxt    = winner;
          wait_cnt_nxt = '0;
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          state_nxt    = RELEASE;
          grant_nxt    = 2'b00;
          wait_cnt_nxt = '0;
        end else if (s.ack) begin
          state_nxt      = RELEASE;
          grant_nxt      = 2'b00;
          last_grant_nxt = grant[1];
          wait_cnt_nxt   = '0;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt    = RELEASE;
          grant_nxt    = 2'b00;
          wait_cnt_nxt = '0;
          timeout_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= 2'b00;
      last_grant    <= 1'b1;
      wait_cnt      <= '0;
      timeout_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      last_grant    <= last_grant_nxt;
      wait_cnt      <= wait_cnt_nxt;
      timeout_error <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench: directed scenarios plus random batches scored against a
// transfer-order / memory model of the arbiter and its shared slave.
`timescale 1ns/1ps
module tb_wishbone_arbiter;
  localparam int TO = 8;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
  typedef struct { int who; logic [31:0] addr; logic we; logic [31:0] rdata; } done_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       timeout_error;
  logic [1:0] grant;

  wishbone_if #(.ADDR_W(32)) m0_if ();
  wishbone_if #(.ADDR_W(32)) m1_if ();
  wishbone_if #(.ADDR_W(32)) s_if ();

  wishbone_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .m0            (m0_if),
    .m1            (m1_if),
    .s             (s_if),
    .timeout_error (timeout_error),
    .grant         (grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 + 32'(i * 32'h111);
  endfunction

  // Shared slave: one-cycle registered ack, 16-word memory.
  bit          slave_en;
  logic [31:0] slave_mem [16];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_if.ack      <= 1'b0;
      s_if.data_out <= '0;
      for (int i = 0; i < 16; i++) slave_mem[i] <= init_word(i);
    end else if (slave_en && s_if.cycle && s_if.strobe && !s_if.ack) begin
      s_if.ack <= 1'b1;
      if (s_if.write_enable) slave_mem[s_if.address[5:2]] <= s_if.data_in;
      else                   s_if.data_out <= slave_mem[s_if.address[5:2]];
    end else begin
      s_if.ack <= 1'b0;
    end
  end

  // Requester queues, observation logs and the reference model state.
  req_t        q0[$], q1[$];
  done_t       done_q[$];
  logic [1:0]  grant_log[$];
  logic [31:0] addr_at_grant[$];
  int          gap_log[$];
  int          cyc = 0, zero_run, to_cnt, viol;
  int          ack_cnt[2], last_ack_cyc[2], busy_cycles[2];
  logic [1:0]  prev_grant, last_owner;
  logic [31:0] model_mem [16];
  bit          model_last;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk_req(logic [31:0] addr, logic we, logic [31:0] wdata);
    req_t r;
    r.addr = addr; r.we = we; r.wdata = wdata;
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
    model_last = 1'b1;
  endfunction

  function automatic void clear_logs();
    done_q.delete(); grant_log.delete(); addr_at_grant.delete(); gap_log.delete();
    zero_run = 0; to_cnt = 0; viol = 0; prev_grant = 2'b00; last_owner = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ack_cnt[i] = 0; last_ack_cyc[i] = -100; busy_cycles[i] = 0;
    end
  endfunction

  task automatic drive_masters();
    if (q0.size() > 0) begin
      m0_if.cycle = 1'b1; m0_if.strobe = 1'b1; m0_if.address = q0[0].addr;
      m0_if.write_enable = q0[0].we; m0_if.data_in = q0[0].wdata;
    end else begin
      m0_if.cycle = 1'b0; m0_if.strobe = 1'b0; m0_if.address = '0;
      m0_if.write_enable = 1'b0; m0_if.data_in = '0;
    end
    if (q1.size() > 0) begin
      m1_if.cycle = 1'b1; m1_if.strobe = 1'b1; m1_if.address = q1[0].addr;
      m1_if.write_enable = q1[0].we; m1_if.data_in = q1[0].wdata;
    end else begin
      m1_if.cycle = 1'b0; m1_if.strobe = 1'b0; m1_if.address = '0;
      m1_if.write_enable = 1'b0; m1_if.data_in = '0;
    end
  endtask

  task automatic take(int who);
    done_t d;
    d.who = who; d.addr = '1; d.we = 1'b0;
    if (cyc - last_ack_cyc[who] < 2) viol++;
    last_ack_cyc[who] = cyc;
    ack_cnt[who]++;
    if (who == 0) begin
      d.rdata = m0_if.data_out;
      if (q0.size() > 0) begin d.addr = q0[0].addr; d.we = q0[0].we; q0.delete(0); end
    end else begin
      d.rdata = m1_if.data_out;
      if (q1.size() > 0) begin d.addr = q1[0].addr; d.we = q1[0].we; q1.delete(0); end
    end
    done_q.push_back(d);
  endtask

  // One clock: drive just after the rising edge, observe on the falling edge.
  task automatic cycle_step();
    @(posedge clk); #1;
    drive_masters();
    @(negedge clk);
    cyc++;
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      grant_log.push_back(grant);
      addr_at_grant.push_back(s_if.address);
      gap_log.push_back(zero_run);
    end
    zero_run   = (grant == 2'b00) ? zero_run + 1 : 0;
    prev_grant = grant;
    if (grant != 2'b00) last_owner = grant;
    if (grant == 2'b01) busy_cycles[0]++;
    if (grant == 2'b10) busy_cycles[1]++;
    if ((m0_if.ack && !m0_if.cycle) || (m1_if.ack && !m1_if.cycle)) viol++;
    if ((m0_if.ack && grant != 2'b01) || (m1_if.ack && grant != 2'b10)) viol++;
    if (grant == 2'b00 && (s_if.cycle || s_if.strobe)) viol++;
    if (m0_if.ack) take(0);
    if (m1_if.ack) take(1);
    if (timeout_error) begin
      to_cnt++;
      if (last_owner == 2'b01 && q0.size() > 0) q0.delete(0);
      else if (last_owner == 2'b10 && q1.size() > 0) q1.delete(0);
    end
  endtask

  task automatic run_until_drained(string tag, int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      cycle_step();
      n++;
    end
    check({tag, "_drained"}, 64'(q0.size() + q1.size()), 64'd0);
    repeat (3) cycle_step();
  endtask

  // Reference: serve in round-robin order, apply writes, predict read data.
  task automatic run_batch(string tag);
    req_t  c0[$], c1[$];
    done_t exp_q[$];
    done_t e;
    req_t  r;
    int    w, n;
    c0 = q0; c1 = q1;
    while (c0.size() > 0 || c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) w = model_last ? 0 : 1;
      else                                w = (c0.size() > 0) ? 0 : 1;
      if (w == 0) begin r = c0[0]; c0.delete(0); end
      else        begin r = c1[0]; c1.delete(0); end
      model_last = (w == 1);
      e.who = w; e.addr = r.addr; e.we = r.we; e.rdata = model_mem[r.addr[5:2]];
      if (r.we) model_mem[r.addr[5:2]] = r.wdata;
      exp_q.push_back(e);
    end
    clear_logs();
    run_until_drained(tag, 8 * exp_q.size() + 20);
    check({tag, "_count"}, 64'(done_q.size()), 64'(exp_q.size()));
    check({tag, "_grants"}, 64'(grant_log.size()), 64'(exp_q.size()));
    n = (done_q.size() < exp_q.size()) ? done_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_who%0d", tag, k), 64'(done_q[k].who), 64'(exp_q[k].who));
      check($sformatf("%s_addr%0d", tag, k), 64'(done_q[k].addr), 64'(exp_q[k].addr));
      if (!exp_q[k].we)
        check($sformatf("%s_rdata%0d", tag, k), 64'(done_q[k].rdata), 64'(exp_q[k].rdata));
      if (k < grant_log.size())
        check($sformatf("%s_grant%0d", tag, k), 64'(grant_log[k]), 64'(2'b01 << exp_q[k].who));
    end
    check({tag, "_protocol"}, 64'(viol), 64'd0);
    check({tag, "_no_timeout"}, 64'(to_cnt), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stimulus
    int n, n0, n1;
    reset    = 1'b0;
    slave_en = 1'b1;
    model_reset();
    clear_logs();
    q0.push_back(mk_req(32'h0000_0004, 1'b0, '0));
    drive_masters();
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state, with m0 already requesting.
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_timeout", 64'(timeout_error), 64'd0);
    check("rst_s_cycle", 64'({s_if.cycle, s_if.strobe, s_if.write_enable}), 64'd0);
    check("rst_s_addr", 64'(s_if.address), 64'd0);
    check("rst_acks", 64'({m0_if.ack, m1_if.ack}), 64'd0);
    reset = 1'b1;

    // m0 alone reads word 1.
    run_batch("m0_read");
    check("m0_read_grant", 64'(grant_log.size() > 0 ? grant_log[0] : 2'b11), 64'(2'b01));
    check("m0_read_saddr", 64'(addr_at_grant.size() > 0 ? addr_at_grant[0] : '1), 64'h4);
    check("m0_read_data", 64'(done_q.size() > 0 ? done_q[0].rdata : '1), 64'(init_word(1)));
    check("m0_read_acks", 64'({ack_cnt[0], ack_cnt[1]}), {32'd1, 32'd0});

    // Tie from reset: m0 first, m1 after the release gap; repeat tie -> m0 again.
    do_reset();
    q0.push_back(mk_req(32'h0000_0008, 1'b0, '0));
    q1.push_back(mk_req(32'h0000_000C, 1'b0, '0));
    run_batch("tie_a");
    check("tie_a_gap", 64'(gap_log.size() > 1 ? gap_log[1] : -1), 64'd2);
    q0.push_back(mk_req(32'h0000_0010, 1'b0, '0));
    q1.push_back(mk_req(32'h0000_0014, 1'b0, '0));
    run_batch("tie_b");
    check("tie_b_first", 64'(grant_log.size() > 0 ? grant_log[0] : 2'b11), 64'(2'b01));

    // Continuous requests from both: strict alternation.
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk_req(32'($urandom_range(0, 15)) << 2, 1'b0, '0));
      q1.push_back(mk_req(32'($urandom_range(0, 15)) << 2, 1'b0, '0));
    end
    run_batch("alt6");

    // Random mixed read/write batches.
    for (int b = 0; b < 6; b++) begin
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      if (n0 + n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++)
        q0.push_back(mk_req(32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)), $urandom));
      for (int i = 0; i < n1; i++)
        q1.push_back(mk_req(32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)), $urandom));
      run_batch($sformatf("rand%0d", b));
    end

    // Silent slave: abort after TO busy cycles with a single-cycle pulse.
    clear_logs();
    slave_en = 1'b0;
    q0.push_back(mk_req(32'h0000_0020, 1'b0, '0));
    repeat (TO + 12) cycle_step();
    check("to_busy_cycles", 64'(busy_cycles[0]), 64'(TO));
    check("to_pulses", 64'(to_cnt), 64'd1);
    check("to_no_ack", 64'(ack_cnt[0] + ack_cnt[1]), 64'd0);
    check("to_protocol", 64'(viol), 64'd0);
    q0.delete();
    slave_en = 1'b1;
    q0.push_back(mk_req(32'h0000_0024, 1'b0, '0));
    run_batch("after_to");

    // Owner drops cycle mid-transfer.
    clear_logs();
    slave_en = 1'b0;
    q1.push_back(mk_req(32'h0000_0028, 1'b0, '0));
    n = 0;
    while (grant != 2'b10 && n < 10) begin cycle_step(); n++; end
    check("drop_granted", 64'(grant), 64'(2'b10));
    repeat (3) cycle_step();
    q1.delete();
    repeat (14) cycle_step();
    check("drop_busy_cycles", 64'(busy_cycles[1]), 64'd5);
    check("drop_no_timeout", 64'(to_cnt), 64'd0);
    check("drop_no_ack", 64'(ack_cnt[0] + ack_cnt[1]), 64'd0);
    check("drop_grant_clear", 64'(grant), 64'd0);
    slave_en = 1'b1;
    q1.push_back(mk_req(32'h0000_002C, 1'b0, '0));
    run_batch("after_drop");

    // Reset asserted mid-BUSY: immediate abort, no ack while held.
    clear_logs();
    slave_en = 1'b0;
    q0.push_back(mk_req(32'h0000_0030, 1'b0, '0));
    n = 0;
    while (grant != 2'b01 && n < 10) begin cycle_step(); n++; end
    check("rstmid_granted", 64'(grant), 64'(2'b01));
    #2 reset = 1'b0;
    #1;
    check("rstmid_grant", 64'(grant), 64'd0);
    check("rstmid_s_cycle", 64'({s_if.cycle, s_if.strobe}), 64'd0);
    check("rstmid_acks", 64'({m0_if.ack, m1_if.ack}), 64'd0);
    slave_en = 1'b1;
    repeat (3) cycle_step();
    q0.delete();
    reset = 1'b1;
    model_reset();
    repeat (3) cycle_step();
    check("rstmid_no_ack", 64'(ack_cnt[0] + ack_cnt[1]), 64'd0);
    check("rstmid_idle", 64'(grant), 64'd0);
    check("rstmid_protocol", 64'(viol), 64'd0);

    // Normal service resumes after reset.
    q0.push_back(mk_req(32'h0000_0034, 1'b0, '0));
    q1.push_back(mk_req(32'h0000_0038, 1'b1, 32'hDEAD_BEEF));
    q1.push_back(mk_req(32'h0000_0038, 1'b0, '0));
    run_batch("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
